// File: rtl/simple_alt_pkg.sv
// Shared types, widths and ALU helpers for the simple_alt ALU.
package simple_alt_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 6;

  typedef enum logic [1:0] {
    OP_ADD3  = 2'd0,
    OP_SUB   = 2'd1,
    OP_LOGIC = 2'd2,
    OP_MAX   = 2'd3
  } op_e;

  // Next mode in the cycle ADD3 -> SUB -> LOGIC -> MAX -> ADD3.
  function automatic op_e op_next(input op_e op);
    return op_e'(2'(op + 2'd1));
  endfunction

  // Result for one operation; SUB wraps naturally into 6-bit two's complement.
  function automatic logic [RES_W-1:0] alu_eval(
    input op_e               op,
    input logic [OPND_W-1:0] a,
    input logic [OPND_W-1:0] b,
    input logic [OPND_W-1:0] c
  );
    logic [RES_W-1:0]  res;
    logic [OPND_W-1:0] mx;
    res = '0;
    mx  = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    case (op)
      OP_ADD3:  res = RES_W'(a) + RES_W'(b) + RES_W'(c);
      OP_SUB:   res = RES_W'(a) + RES_W'(b) - RES_W'(c);
      OP_LOGIC: res = RES_W'((a & b) | c);
      OP_MAX:   res = RES_W'(mx);
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/simple_alt_pb_edge.sv
// Push-button synchronizer with optional debounce and single-cycle rise pulse.
// Debounce is compiled in with SIMPLE_ALT_PB_DEBOUNCE_EN.
module simple_alt_pb_edge #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic PB,
  output logic rise
);

  logic pb_s1_q;
  logic pb_s2_q;
  logic pb_d_q;
  logic lvl_c;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pb_s1_q <= 1'b0;
      pb_s2_q <= 1'b0;
    end else begin
      pb_s1_q <= PB;
      pb_s2_q <= pb_s1_q;
    end
  end

`ifdef SIMPLE_ALT_PB_DEBOUNCE_EN
  localparam int unsigned CNT_W = 8;

  logic             pb_db_q;
  logic             pb_db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept a new level only after it has persisted for DB_CYCLES cycles.
  always_comb begin
    pb_db_d = pb_db_q;
    cnt_d   = '0;
    if (pb_s2_q != pb_db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        pb_db_d = pb_s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pb_db_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pb_db_q <= pb_db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_c = pb_db_q;
`else
  logic unused_db_c;

  assign unused_db_c = ^8'(DB_CYCLES);
  assign lvl_c       = pb_s2_q;
`endif

  // Previous level for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pb_d_q <= 1'b0;
    end else begin
      pb_d_q <= lvl_c;
    end
  end

  assign rise = lvl_c & ~pb_d_q;

endmodule

// File: rtl/simple_alt_alu.sv
// Registered three-operand ALU; PB rising edges step the operating mode.
// Optional PB debounce via SIMPLE_ALT_PB_DEBOUNCE_EN.
module simple_alt_alu
  import simple_alt_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [OPND_W-1:0] P,
  input  logic [OPND_W-1:0] Q,
  input  logic [OPND_W-1:0] R,
  input  logic              PB,
  output logic [RES_W-1:0]  S
);

  logic             rise;
  op_e              mode_q;
  op_e              mode_d;
  logic [RES_W-1:0] s_q;
  logic [RES_W-1:0] s_d;

  simple_alt_pb_edge #(
    .DB_CYCLES (DB_CYCLES)
  ) u_pb_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .PB     (PB),
    .rise   (rise)
  );

  // Mode step and result computed from the pre-increment mode.
  always_comb begin
    mode_d = mode_q;
    s_d    = alu_eval(mode_q, P, Q, R);
    if (rise) begin
      mode_d = op_next(mode_q);
    end
  end

  // Mode and result registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= OP_ADD3;
      s_q    <= '0;
    end else begin
      mode_q <= mode_d;
      s_q    <= s_d;
    end
  end

  assign S = s_q;

endmodule

// File: tb/tb_simple_alt_alu.sv
// Directed self-checking bench for simple_alt_alu.
module tb_simple_alt_alu;

  localparam int unsigned DB = 4;
`ifdef SIMPLE_ALT_PB_DEBOUNCE_EN
  localparam int unsigned HOLD   = DB + 2;
  localparam int unsigned SETTLE = DB + 6;
`else
  localparam int unsigned HOLD   = 4;
  localparam int unsigned SETTLE = 6;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] p;
  logic [3:0] q;
  logic [3:0] r;
  logic       pb;
  logic [5:0] s;

  int n_checks;
  int n_errors;

  simple_alt_alu #(
    .DB_CYCLES (DB)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .P      (p),
    .Q      (q),
    .R      (r),
    .PB     (pb),
    .S      (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    p = a;
    q = b;
    r = c;
  endtask

  task automatic press(input int hold);
    pb = 1'b1;
    tick(hold);
    pb = 1'b0;
    tick(SETTLE);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pb       = 1'b0;
    set_ops(4'd15, 4'd15, 4'd15);
    rst_n    = 1'b0;
    #1;
    check("reset_async", s, 6'd0);
    @(negedge clk);
    tick(2);
    check("reset_hold", s, 6'd0);

    rst_n = 1'b1;
    tick(1);
    check("add3_max", s, 6'h2D);

    set_ops(4'd3, 4'd4, 4'd5);
    tick(1);
    check("add3_345", s, 6'd12);
    set_ops(4'd0, 4'd0, 4'd0);
    tick(1);
    check("add3_zero", s, 6'd0);

    set_ops(4'd1, 4'd2, 4'd9);
`ifdef SIMPLE_ALT_PB_DEBOUNCE_EN
    press(HOLD);
    check("sub_neg6", s, 6'h3A);
`else
    pb = 1'b1;
    tick(1);
    check("lat_e0", s, 6'd12);
    tick(1);
    check("lat_e1", s, 6'd12);
    set_ops(4'd2, 4'd2, 4'd2);
    tick(1);
    check("lat_same_edge_old_mode", s, 6'd6);
    tick(1);
    check("lat_new_mode", s, 6'd2);
    pb = 1'b0;
    set_ops(4'd1, 4'd2, 4'd9);
    tick(SETTLE);
    check("sub_neg6", s, 6'h3A);
`endif

    set_ops(4'd15, 4'd15, 4'd0);
    tick(1);
    check("sub_max", s, 6'd30);

    press(HOLD);
    set_ops(4'hA, 4'h6, 4'h1);
    tick(1);
    check("logic", s, 6'd3);

    press(HOLD);
    set_ops(4'd3, 4'd12, 4'd7);
    tick(1);
    check("max", s, 6'd12);

    press(HOLD);
    set_ops(4'd1, 4'd1, 4'd1);
    tick(1);
    check("wrap_add3", s, 6'd3);

    // ADD3=12, SUB=0x3A, LOGIC=MAX=9 for these operands.
    set_ops(4'd1, 4'd2, 4'd9);
    pb = 1'b1;
    tick(100);
    check("hold_one_step", s, 6'h3A);
    pb = 1'b0;
    tick(SETTLE);
    check("fall_no_step", s, 6'h3A);

    press(HOLD);
    press(HOLD);
    set_ops(4'd3, 4'd12, 4'd7);
    tick(1);
    check("max_before_reset", s, 6'd12);
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", s, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("after_reset_add3", s, 6'd22);

    set_ops(4'd1, 4'd2, 4'd9);
    pb    = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(SETTLE);
    check("pb_high_at_release", s, 6'h3A);
    pb = 1'b0;
    tick(SETTLE);
    check("pb_release_no_step", s, 6'h3A);

`ifdef SIMPLE_ALT_PB_DEBOUNCE_EN
    press(3);
    check("db_short_ignored", s, 6'h3A);
    press(5);
    check("db_long_accepted", s, 6'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simple_alt_alu.md
Name: simple_alt_alu

Overview:
- Small registered ALU combining three 4-bit operands P, Q, R into a 6-bit result S.
- The operation is selected by an internal 2-bit mode register.
- The mode advances one step on each rising edge of the push-button input PB, wrapping 3 -> 0.
- The block sits between board switches/buttons and a display driver.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required before the debounced PB level changes (used only when the debounce feature is compiled in; legal range 2..255).

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_n   input  1  asynchronous active-low reset.
- P       input  4  operand A, unsigned.
- Q       input  4  operand B, unsigned.
- R       input  4  operand C, unsigned.
- PB      input  1  asynchronous push-button; a rising edge advances the mode.
- S       output 6  registered result.

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: S=6'd0, mode=OP_ADD3, all synchronizer/edge/debounce flops=0.
- Modes (2-bit, reset value 0):
  - OP_ADD3 (0): S = P+Q+R, zero-extended unsigned; max 45, no overflow.
  - OP_SUB (1): S = P+Q-R in 6-bit two's complement; range -15..30, no overflow.
  - OP_LOGIC (2): S = {2'b00, (P & Q) | R}.
  - OP_MAX (3): S = {2'b00, max(P,Q,R)}, unsigned compare.
- Result path: S is registered from P/Q/R and the current mode. P/Q/R sampled at edge k appear on S after edge k. Latency is 1 cycle.
- P/Q/R are used directly with no synchronizer; they are treated as quasi-static.
- PB path:
  - Two-flop synchronizer pb_s1 -> pb_s2, then a previous-value flop pb_d.
  - rise = pb_s2 & ~pb_d.
  - Mode increments by 1 on an edge where rise=1, wrapping 3 -> 0.
  - PB high before edge k: pb_s2=1 after edge k+1, mode increments at edge k+2, S reflects the new mode at edge k+3.
- Holding PB high produces exactly one increment. A falling PB edge has no effect. Minimum PB high time: 2 clocks.
- A PB rise and an operand change in the same cycle: S uses the mode value before the increment on that edge.
- Reset asserted mid-operation: mode returns to OP_ADD3 and S clears immediately. A PB level still high at reset release produces one increment once it propagates through the synchronizer.

Optional Feature:
- Macro SIMPLE_ALT_PB_DEBOUNCE_EN.
- Defined:
  - A counter tracks how long pb_s2 has differed from the debounced level pb_db.
  - When it has differed for DB_CYCLES consecutive cycles, pb_db takes pb_s2 and the counter clears. Any return to equality clears the counter.
  - Edge detect uses pb_db in place of pb_s2.
  - PB-to-mode latency becomes 2+DB_CYCLES edges; pulses shorter than DB_CYCLES cycles are ignored.
- Undefined: no counter; edge detect on pb_s2 as described above.

Decomposition:
- Package simple_alt_pkg:
  - typedef enum logic [1:0] op_e {OP_ADD3=0, OP_SUB=1, OP_LOGIC=2, OP_MAX=3}.
  - Constants OPND_W=4 and RES_W=6.
- Sub-module simple_alt_pb_edge: synchronizer, optional debounce, and rise-pulse output. Parameterized by DB_CYCLES; ports clk_in, rst_n, PB, rise.
- Top: mode register, combinational ALU, S register.

Test Plan:
- Reset: rst_n=0 with P=Q=R=15 -> S=0 immediately. Release reset, hold PB=0 -> S=45 (6'h2D) one cycle later (OP_ADD3).
- OP_ADD3 sweep: P=3, Q=4, R=5 -> S=12. P=0, Q=0, R=0 -> S=0. Each result appears one cycle after the operand change.
- One PB press (high 4 cycles) -> OP_SUB:
  - P=1, Q=2, R=9 -> S=6'h3A (-6).
  - P=15, Q=15, R=0 -> S=30.
  - Mode changes exactly 3 edges after PB rises (without debounce).
- Second press -> OP_LOGIC: P=4'hA, Q=4'h6, R=4'h1 -> S=3. Third press -> OP_MAX: P=3, Q=12, R=7 -> S=12.
- Wrap and hold: a fourth press returns to OP_ADD3 (P=Q=R=1 -> S=3). PB held high 100 cycles -> exactly one increment; PB falling -> no change.
- Reset mid-run in OP_MAX -> S=0 and mode=OP_ADD3 after release. With SIMPLE_ALT_PB_DEBOUNCE_EN and DB_CYCLES=4: a 3-cycle PB pulse causes no mode change; a 5-cycle pulse causes one.
